// File: rtl/led16_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led16_pkg                                                            |
// | Shared types and helpers for the LED16 display arbiter.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package led16_pkg;

    localparam int LED_W = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led16_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led16_rr_pick                                                        |
// | Combinational round-robin picker with optional excluded index.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module led16_rr_pick
    import led16_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = idx_w(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] start,
    input  logic             excl_en,
    input  logic [IDX_W-1:0] excl_idx,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);

    logic [IDX_W-1:0] w_cand;

    // First requester found walking upward from start, wrapping at NREQ.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        w_cand = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = IDX_W'((int'(start) + i) % NREQ);
            if (!valid && req[w_cand] && !(excl_en && (w_cand == excl_idx))) begin
                valid  = 1'b1;
                winner = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/led16_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led16_arbiter                                                        |
// | Round-robin owner arbitration with minimum hold for the LED16 driver.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module led16_arbiter
    import led16_pkg::*;
#(
    parameter int          NREQ         = 4,
    parameter int          HOLD_CYCLES  = 1024,
    parameter logic [15:0] IDLE_PATTERN = 16'h0000
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*LED_W-1:0]     data,
    output logic [NREQ-1:0]           grant,
    output logic [idx_w(NREQ)-1:0]    owner,
    output logic                      busy,
    output logic [LED_W-1:0]          ledbits
);

    localparam int c_idx_w = idx_w(NREQ);
    localparam int c_cnt_w = $clog2(HOLD_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_hold_reload = c_cnt_w'(HOLD_CYCLES - 1);

    arb_state_t          r_state;
    logic [c_cnt_w-1:0]  r_hold;
    logic [c_idx_w-1:0]  r_rr_start;

    logic                w_excl_en;
    logic                w_valid;
    logic [c_idx_w-1:0]  w_winner;
    logic [c_idx_w-1:0]  w_next_start;
    logic                w_owner_req;
    logic                w_take;
    logic [LED_W-1:0]    w_owner_data;
    logic [LED_W-1:0]    w_winner_data;

    // While owning, the current owner never competes against itself.
    assign w_excl_en = (r_state == OWN);

    led16_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (c_idx_w)
    ) u_pick (
        .req      (req),
        .start    (r_rr_start),
        .excl_en  (w_excl_en),
        .excl_idx (owner),
        .valid    (w_valid),
        .winner   (w_winner)
    );

    assign w_owner_req   = req[owner];
    assign w_owner_data  = data[LED_W*int'(owner) +: LED_W];
    assign w_winner_data = data[LED_W*int'(w_winner) +: LED_W];
    assign w_next_start  = (w_winner == c_idx_w'(NREQ - 1)) ? '0 : w_winner + 1'b1;

    // A new grant happens from idle, on owner drop, or on hold expiry under contention.
    assign w_take = w_valid && ((r_state == IDLE) || !w_owner_req || (r_hold == '0));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            grant      <= '0;
            owner      <= '0;
            busy       <= 1'b0;
            ledbits    <= IDLE_PATTERN;
            r_hold     <= '0;
            r_rr_start <= '0;
        end else if (w_take) begin
            r_state    <= OWN;
            grant      <= NREQ'(1) << w_winner;
            owner      <= w_winner;
            busy       <= 1'b1;
            ledbits    <= w_winner_data;
            r_hold     <= c_hold_reload;
            r_rr_start <= w_next_start;
        end else if (r_state == OWN) begin
            if (!w_owner_req) begin
                r_state <= IDLE;
                grant   <= '0;
                busy    <= 1'b0;
                ledbits <= IDLE_PATTERN;
                r_hold  <= '0;
            end else begin
                ledbits <= w_owner_data;
                if (r_hold != '0) begin
                    r_hold <= r_hold - 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led16_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_led16_arbiter                                                     |
// | Scoreboard bench for led16_arbiter with NREQ=4, HOLD_CYCLES=8.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_led16_arbiter;

    localparam int NREQ = 4;
    localparam int HOLD = 8;

    typedef struct packed {
        logic [3:0]  grant;
        logic [1:0]  owner;
        logic        busy;
        logic [15:0] led;
    } snap_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  req = '0;
    logic [63:0] data = '0;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        busy;
    logic [15:0] ledbits;

    int    vectors = 0;
    int    miscompares = 0;
    snap_t sb[$];

    always #5 clk = ~clk;

    led16_arbiter #(
        .NREQ         (NREQ),
        .HOLD_CYCLES  (HOLD),
        .IDLE_PATTERN (16'h0000)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req),
        .data    (data),
        .grant   (grant),
        .owner   (owner),
        .busy    (busy),
        .ledbits (ledbits)
    );

    function automatic snap_t mk(logic [3:0] g, logic [1:0] o, logic b, logic [15:0] l);
        snap_t s;
        s.grant = g;
        s.owner = o;
        s.busy  = b;
        s.led   = l;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        snap_t e, o;
        req = '0;
        tick();
        tick();
        resetn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            sb.push_back(mk(4'b0000, 2'd0, 1'b0, 16'h0000));
            tick();
            e = sb.pop_front();
            o = mk(grant, owner, busy, ledbits);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset[%0d]: got g/o/b/led=%h want %h", c, o, e);
            end
        end
    endtask

    task automatic test_single();
        snap_t e, o;
        data[47:32] = 16'hA5A5;
        req = 4'b0100;
        sb.push_back(mk(4'b0100, 2'd2, 1'b1, 16'hA5A5));
        tick();
        e = sb.pop_front();
        o = mk(grant, owner, busy, ledbits);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL single_grant: got g/o/b/led=%h want %h", o, e);
        end
        data[47:32] = 16'h1234;
        sb.push_back(mk(4'b0100, 2'd2, 1'b1, 16'h1234));
        tick();
        e = sb.pop_front();
        o = mk(grant, owner, busy, ledbits);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL single_follow: got g/o/b/led=%h want %h", o, e);
        end
        req = 4'b0000;
        sb.push_back(mk(4'b0000, 2'd2, 1'b0, 16'h0000));
        tick();
        e = sb.pop_front();
        o = mk(grant, owner, busy, ledbits);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL single_release: got g/o/b/led=%h want %h", o, e);
        end
    endtask

    task automatic test_rotation();
        snap_t e, o;
        int g;
        do_reset();
        for (int i = 0; i < NREQ; i++) data[16*i +: 16] = 16'hC000 | 16'(i);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            g = k % NREQ;
            for (int c = 0; c < HOLD; c++) begin
                sb.push_back(mk(4'b0001 << g, 2'(g), 1'b1, 16'hC000 | 16'(g)));
                tick();
                e = sb.pop_front();
                o = mk(grant, owner, busy, ledbits);
                vectors++;
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL rotation[%0d.%0d]: got g/o/b/led=%h want %h", k, c, o, e);
                end
            end
        end
        req = 4'b0000;
        sb.push_back(mk(4'b0000, 2'd0, 1'b0, 16'h0000));
        tick();
        e = sb.pop_front();
        o = mk(grant, owner, busy, ledbits);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL rotation_idle: got g/o/b/led=%h want %h", o, e);
        end
    endtask

    // Pointer is 1 here, so req 1010 grants 1 first.
    task automatic test_drop();
        snap_t e, o;
        req = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            sb.push_back(mk(4'b0010, 2'd1, 1'b1, 16'hC001));
            tick();
            e = sb.pop_front();
            o = mk(grant, owner, busy, ledbits);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL drop_own1[%0d]: got g/o/b/led=%h want %h", c, o, e);
            end
        end
        req = 4'b1001;
        for (int c = 0; c < HOLD; c++) begin
            sb.push_back(mk(4'b1000, 2'd3, 1'b1, 16'hC003));
            tick();
            e = sb.pop_front();
            o = mk(grant, owner, busy, ledbits);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL drop_own3[%0d]: got g/o/b/led=%h want %h", c, o, e);
            end
        end
        sb.push_back(mk(4'b0001, 2'd0, 1'b1, 16'hC000));
        tick();
        e = sb.pop_front();
        o = mk(grant, owner, busy, ledbits);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL drop_reload_expiry: got g/o/b/led=%h want %h", o, e);
        end
        req = 4'b0000;
        sb.push_back(mk(4'b0000, 2'd0, 1'b0, 16'h0000));
        tick();
        e = sb.pop_front();
        o = mk(grant, owner, busy, ledbits);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL drop_idle: got g/o/b/led=%h want %h", o, e);
        end
    endtask

    task automatic test_long_hold();
        snap_t e, o;
        req = 4'b0001;
        for (int c = 0; c < 50; c++) begin
            sb.push_back(mk(4'b0001, 2'd0, 1'b1, 16'hC000));
            tick();
            e = sb.pop_front();
            o = mk(grant, owner, busy, ledbits);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL long_own0[%0d]: got g/o/b/led=%h want %h", c, o, e);
            end
        end
        req = 4'b0101;
        sb.push_back(mk(4'b0100, 2'd2, 1'b1, 16'hC002));
        tick();
        e = sb.pop_front();
        o = mk(grant, owner, busy, ledbits);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL long_handover: got g/o/b/led=%h want %h", o, e);
        end
        req = 4'b0000;
        sb.push_back(mk(4'b0000, 2'd2, 1'b0, 16'h0000));
        tick();
        e = sb.pop_front();
        o = mk(grant, owner, busy, ledbits);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL long_idle: got g/o/b/led=%h want %h", o, e);
        end
    endtask

    // Owner 1 leaves the pointer at 2, so a surviving pointer would pick 2 next.
    task automatic test_async_reset();
        snap_t e, o;
        req = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            sb.push_back(mk(4'b0010, 2'd1, 1'b1, 16'hC001));
            tick();
            e = sb.pop_front();
            o = mk(grant, owner, busy, ledbits);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL areset_own[%0d]: got g/o/b/led=%h want %h", c, o, e);
            end
        end
        #2;
        resetn = 1'b0;
        sb.push_back(mk(4'b0000, 2'd0, 1'b0, 16'h0000));
        #1;
        e = sb.pop_front();
        o = mk(grant, owner, busy, ledbits);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL areset_immediate: got g/o/b/led=%h want %h", o, e);
        end
        req = 4'b0110;
        sb.push_back(mk(4'b0000, 2'd0, 1'b0, 16'h0000));
        tick();
        e = sb.pop_front();
        o = mk(grant, owner, busy, ledbits);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL areset_held: got g/o/b/led=%h want %h", o, e);
        end
        #3;
        resetn = 1'b1;
        sb.push_back(mk(4'b0010, 2'd1, 1'b1, 16'hC001));
        tick();
        e = sb.pop_front();
        o = mk(grant, owner, busy, ledbits);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL areset_first_grant: got g/o/b/led=%h want %h", o, e);
        end
        req = 4'b0000;
        sb.push_back(mk(4'b0000, 2'd1, 1'b0, 16'h0000));
        tick();
        e = sb.pop_front();
        o = mk(grant, owner, busy, ledbits);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL areset_idle: got g/o/b/led=%h want %h", o, e);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_drop();
        test_long_hold();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, got running want finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/led16_arbiter.md
# led16_arbiter

Shares the single 16-bit LED matrix display (the `LED16` multiplex driver) between several independent requesters. Each requester asks for the display with a level request, receives a one-hot grant, and has its pattern shown for a guaranteed minimum time. Ownership then rotates round-robin if others are waiting. The block sits directly in front of the LED multiplex driver and drives its `ledbits` input; when nobody owns the display, a fixed idle pattern is shown.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `HOLD_CYCLES`, 1024: minimum owned time in clk cycles before pre-emption by another requester, ≥1.
- `IDLE_PATTERN`, 16'h0000: `ledbits` value while no owner.

Ports:
- `clk`, in, 1: single clock, all logic on rising edge.
- `resetn`, in, 1: asynchronous, active-low reset.
- `req`, in, NREQ: level request per requester; held high for as long as it wants the display.
- `data`, in, NREQ*16: requester i's pattern at bits [16i+15:16i].
- `grant`, out, NREQ: one-hot owner, or all-zero.
- `owner`, out, max(1,$clog2(NREQ)): index of current owner; holds the last owner while idle.
- `busy`, out, 1: high while any grant is asserted.
- `ledbits`, out, 16: registered pattern for the LED driver.

## Operation
- States: IDLE, OWN.
- Reset values: state IDLE, `grant`=0, `owner`=0, `busy`=0, `ledbits`=IDLE_PATTERN, hold counter 0, RR pointer 0.
- Round-robin pick: search starts at (last owner + 1) mod NREQ and wraps. Before the first grant the search starts at 0.
- IDLE:
  - With any `req` set, the winner is granted on the next edge and the state becomes OWN.
  - The hold counter loads HOLD_CYCLES-1.
  - `ledbits` loads the winner's data.
- OWN, every cycle:
  - `ledbits` <= data of `owner`.
  - The hold counter decrements while it is non-zero and saturates at 0.
- OWN, owner's `req` low:
  - Release on the next edge regardless of the hold counter.
  - If another requester is pending, grant the RR winner directly (no idle cycle) and reload the counter.
  - Otherwise go to IDLE with `grant`=0 and `ledbits`=IDLE_PATTERN.
- OWN, counter is 0, owner still requesting, and any other `req` high:
  - The next RR winner (excluding the current owner) is granted on the next edge.
  - The counter reloads.
- OWN, counter is 0, no other request: the owner keeps the display indefinitely.
- Simultaneous owner drop and hold expiry: treated as a drop; the result is the same as the drop case.
- A `req` that falls before it is granted is ignored and no state is kept.
- `req` bits for nonexistent indices do not exist: NREQ fixes the width.
- `resetn` low mid-operation: all outputs return asynchronously to their reset values and the RR pointer returns to 0.

## Timing
- Request-to-grant latency: 1 cycle from the edge that samples `req` high in IDLE.
- `grant`, `owner`, `busy` and `ledbits` change on the same edge.
- `ledbits` follows the owner's `data` with 1-cycle latency.
- Handover between two requesters takes zero idle cycles: the old grant falls and the new grant rises on the same edge.
- Minimum ownership under contention is exactly HOLD_CYCLES cycles, counted from the grant edge to the handover edge.
- With HOLD_CYCLES=1, contending requesters rotate every cycle.
- Counter width is $clog2(HOLD_CYCLES+1). No arithmetic wraps; the counter saturates at 0.
- All outputs are registered; no combinational path from `req` or `data` to any output.

## Structure
- Package `led16_pkg`:
  - `LED_W`=16.
  - State enum `arb_state_t` {IDLE, OWN}.
  - Function `idx_w(n)` returning max(1,$clog2(n)).
- Sub-module `led16_rr_pick`: combinational round-robin priority picker.
  - Inputs: request vector, start index, exclude-enable plus exclude index.
  - Outputs: valid, winner index.
- The top level holds the FSM, hold counter and output registers, and instantiates `led16_rr_pick` once.

## Test plan
Bench settings: NREQ=4, HOLD_CYCLES=8.
- Reset, no `req` -> `grant`=0, `busy`=0, `ledbits`=16'h0000, for 20 cycles.
- `req`=4'b0100 with data2=16'hA5A5 -> one cycle later `grant`=4'b0100, `owner`=2, `ledbits`=16'hA5A5; change data2 to 16'h1234 -> `ledbits`=16'h1234 next cycle.
- `req`=4'b1111 held -> grants 0,1,2,3,0 in order, each exactly 8 cycles, with no gap cycles.
- Owner 1 drops `req` 3 cycles after its grant while `req[3]` is high -> `grant`=4'b1000 on the next edge, with the counter reloaded to 7.
- Owner 0 alone for 50 cycles, then `req[2]` rises -> handover to 2 exactly 1 cycle later (the hold has long expired).
- `resetn` pulsed low mid-ownership, asynchronously between edges -> `grant`=0 and `ledbits`=16'h0000 immediately; after release with `req`=4'b0110, the first grant goes to 1 (RR pointer reset to 0).
